// File: rtl/rv_mc_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv_mc_ctrl_pkg : shared state, opcode and mux-select codes for the core    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package rv_mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_EXEC_U   = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WR   = 4'd8,
        ST_WB_ALU   = 4'd9,
        ST_WB_MEM   = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JAL      = 4'd12,
        ST_JALR     = 4'd13,
        ST_TRAP     = 4'd14
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b01;
    localparam logic [1:0] SRCA_ZERO   = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_CMP   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] WB_ALUOUT   = 2'b00;
    localparam logic [1:0] WB_MEMDATA  = 2'b01;
    localparam logic [1:0] WB_PC4      = 2'b10;

    function automatic state_e decode_next(input logic [6:0] opcode);
        state_e nxt;
        case (opcode)
            OPC_OP:               nxt = ST_EXEC_R;
            OPC_OPIMM:            nxt = ST_EXEC_I;
            OPC_LUI, OPC_AUIPC:   nxt = ST_EXEC_U;
            OPC_LOAD, OPC_STORE:  nxt = ST_MEM_ADDR;
            OPC_BRANCH:           nxt = ST_BRANCH;
            OPC_JAL:              nxt = ST_JAL;
            OPC_JALR:             nxt = ST_JALR;
            default:              nxt = ST_TRAP;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv_wait_timer : 8-bit handshake wait counter with timeout compare          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rv_wait_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // Expired flags the waiting cycle whose increment lands on TIMEOUT_CYC.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else if (clear_i) begin
            cnt_q <= 8'd0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign expired_o = (cnt_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/rv_mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv_mc_ctrl : multi-cycle RV32I control FSM with handshake timeout trap     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rv_mc_ctrl
    import rv_mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic       imem_ready_i,
    input  logic       dmem_ready_i,
    input  logic       branch_taken_i,
    output logic       imem_req_o,
    output logic       dmem_req_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_src_o,
    output logic [1:0] wb_sel_o,
    output logic       trap_o,
    output logic       bus_err_o,
    output logic [3:0] state_o
);

    state_e state_q, state_d;
    logic   bus_err_q, bus_err_d;
    logic   w_wait_en;
    logic   w_wait_clr;
    logic   w_wait_expired;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Any state change restarts the wait count, so each handshake state starts at zero.
    assign w_wait_clr = (state_d != state_q);

    rv_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (w_wait_clr),
        .enable_i  (w_wait_en),
        .expired_o (w_wait_expired)
    );

    always_comb begin
        state_d     = state_q;
        bus_err_d   = bus_err_q;
        w_wait_en   = 1'b0;
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        mem_write_o = 1'b0;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        reg_write_o = 1'b0;
        alu_src_a_o = SRCA_PC;
        alu_src_b_o = SRCB_RS2;
        alu_op_o    = ALUOP_ADD;
        pc_src_o    = PCSRC_ALU;
        wb_sel_o    = WB_ALUOUT;
        trap_o      = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req_o  = 1'b1;
                alu_src_a_o = SRCA_PC;
                alu_src_b_o = SRCB_FOUR;
                alu_op_o    = ALUOP_ADD;
                if (imem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    pc_src_o   = PCSRC_ALU;
                    state_d    = ST_DECODE;
                end else begin
                    w_wait_en = 1'b1;
                    if (w_wait_expired) begin
                        state_d   = ST_TRAP;
                        bus_err_d = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                alu_src_a_o = SRCA_PC;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_ADD;
                state_d     = decode_next(opcode_i);
            end
            ST_EXEC_R: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_RS2;
                alu_op_o    = ALUOP_FUNCT;
                state_d     = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_FUNCT;
                state_d     = ST_WB_ALU;
            end
            ST_EXEC_U: begin
                // opcode bit 5 separates LUI (zero + imm) from AUIPC (pc + imm).
                alu_src_a_o = opcode_i[5] ? SRCA_ZERO : SRCA_PC;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_ADD;
                state_d     = ST_WB_ALU;
            end
            ST_MEM_ADDR: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_ADD;
                state_d     = opcode_i[5] ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD, ST_MEM_WR: begin
                dmem_req_o  = 1'b1;
                mem_write_o = (state_q == ST_MEM_WR);
                if (dmem_ready_i) begin
                    state_d = (state_q == ST_MEM_WR) ? ST_FETCH : ST_WB_MEM;
                end else begin
                    w_wait_en = 1'b1;
                    if (w_wait_expired) begin
                        state_d   = ST_TRAP;
                        bus_err_d = 1'b1;
                    end
                end
            end
            ST_WB_ALU: begin
                reg_write_o = 1'b1;
                wb_sel_o    = WB_ALUOUT;
                state_d     = ST_FETCH;
            end
            ST_WB_MEM: begin
                reg_write_o = 1'b1;
                wb_sel_o    = WB_MEMDATA;
                state_d     = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_RS2;
                alu_op_o    = ALUOP_CMP;
                pc_write_o  = branch_taken_i;
                pc_src_o    = PCSRC_ALUOUT;
                state_d     = ST_FETCH;
            end
            ST_JAL: begin
                pc_write_o  = 1'b1;
                pc_src_o    = PCSRC_ALUOUT;
                reg_write_o = 1'b1;
                wb_sel_o    = WB_PC4;
                state_d     = ST_FETCH;
            end
            ST_JALR: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                alu_op_o    = ALUOP_ADD;
                pc_write_o  = 1'b1;
                pc_src_o    = PCSRC_ALU;
                reg_write_o = 1'b1;
                wb_sel_o    = WB_PC4;
                state_d     = ST_FETCH;
            end
            ST_TRAP: trap_o = 1'b1;
            default: state_d = ST_TRAP;
        endcase
    end

    assign bus_err_o = bus_err_q;
    assign state_o   = state_q;

endmodule
`default_nettype wire
